// File: rtl/furv_pkg.sv
// furv_pkg: FSM states, alu op codes, branch comparison codes and opcodes shared by the furv cores
package furv_pkg;
  typedef enum logic [1:0] {FETCH, EXEC, MEM, WB} state_t;
  // alu ops are {funct7[5], funct3} so the decoder can pass them straight through
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000, ALU_SLL = 4'b0001, ALU_SLT = 4'b0010, ALU_SLTU = 4'b0011,
    ALU_XOR = 4'b0100, ALU_SRL = 4'b0101, ALU_OR = 4'b0110, ALU_AND = 4'b0111,
    ALU_SUB = 4'b1000, ALU_SRA = 4'b1101, ALU_PASSB = 4'b1111
  } alu_op_t;
  localparam logic [1:0] CMP_EQ = 2'd0, CMP_LT = 2'd2, CMP_LTU = 2'd3;
  localparam logic [6:0] OPC_OPIMM = 7'h13, OPC_OP = 7'h33, OPC_LUI = 7'h37;
  localparam logic [6:0] OPC_LOAD = 7'h03, OPC_STORE = 7'h23, OPC_BRANCH = 7'h63;
endpackage

// File: rtl/furv_alu.sv
// furv_alu: combinational integer alu
module furv_alu
  import furv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);
  localparam int SW = $clog2(XLEN);
  logic [SW-1:0] sh;
  assign sh = b[SW-1:0];
  always_comb
    case (alu_op_t'(op))
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << sh;
      ALU_SLT:  y = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: y = XLEN'(a < b);
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> sh;
      ALU_SRA:  y = XLEN'($signed(a) >>> sh);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = b;
    endcase
endmodule

// File: rtl/furv_decoder.sv
// furv_decoder: splits a 32-bit instruction into register indices, immediate and control
module furv_decoder
  import furv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ir,
  output logic [4:0]      ra,
  output logic [4:0]      rb,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_op,
  output logic            sel_imm_b,
  output logic            branch,
  output logic            mem,
  output logic            mem_read,
  output logic            wb,
  output logic [2:0]      comparison
);
  logic op_i, op_r, lui, load, store;
  logic [31:0] imm32;
  assign op_i = ir[6:0] == OPC_OPIMM;
  assign op_r = ir[6:0] == OPC_OP;
  assign lui = ir[6:0] == OPC_LUI;
  assign load = ir[6:0] == OPC_LOAD;
  assign store = ir[6:0] == OPC_STORE;
  assign branch = ir[6:0] == OPC_BRANCH;
  assign ra = ir[19:15];
  assign rb = ir[24:20];
  assign rd = ir[11:7];
  assign comparison = ir[14:12];
  assign mem = load | store;
  assign mem_read = load;
  assign wb = op_i | op_r | lui | load;
  assign sel_imm_b = !op_r;
  assign imm32 = store  ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
                 branch ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
                 lui    ? {ir[31:12], 12'h0} : {{20{ir[31]}}, ir[31:20]};
  assign imm = XLEN'($signed(imm32));
  // funct7[5] only selects sub/sra; for immediates it is an immediate bit except on shifts
  assign alu_op = lui ? ALU_PASSB :
                  (op_r || (op_i && ir[14:12] == 3'd5)) ? {ir[30], ir[14:12]} :
                  op_i ? {1'b0, ir[14:12]} : ALU_ADD;
endmodule

// File: rtl/furv_regfile.sv
// furv_regfile: register file with two async read ports, one write port and async clear
module furv_regfile #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra,
  input  logic [4:0]      rb,
  input  logic [4:0]      rd,
  input  logic            we,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rda,
  output logic [XLEN-1:0] rdb
);
  localparam int AW = $clog2(NREGS);
  logic [XLEN-1:0] r [NREGS];
  // indices past NREGS and a hardwired x0 behave as constant zero
  function automatic logic live(input logic [4:0] i);
    return 32'(i) < NREGS && !(ZERO_REG != 0 && i == 5'd0);
  endfunction
  assign rda = live(ra) ? r[ra[AW-1:0]] : '0;
  assign rdb = live(rb) ? r[rb[AW-1:0]] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NREGS; i++) r[i] <= '0;
    else if (we && live(rd)) r[rd[AW-1:0]] <= wd;
endmodule

// File: rtl/furv_mc.sv
// furv_mc: multi-cycle furv core, FETCH -> EXEC -> (MEM) -> WB over req/ack memory handshakes
module furv_mc
  import furv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            retire,
  output logic [XLEN-1:0] pc
);
  state_t state;
  logic [31:0] ir;
  logic [XLEN-1:0] d_q, wdata_q, ld_q, imm, ra_v, rb_v, alu_y;
  logic [4:0] ra, rb, rd;
  logic [3:0] alu_op;
  logic [2:0] comparison;
  logic sel_imm_b, branch, mem, mem_read, wb, taken_q, cmp;
  assign imem_addr = pc;
  assign dmem_addr = d_q;
  assign dmem_wdata = wdata_q;
  assign cmp = (comparison[2:1] == CMP_EQ ? ra_v == rb_v :
                comparison[2:1] == CMP_LT ? $signed(ra_v) < $signed(rb_v) : ra_v < rb_v) ^ comparison[0];
  furv_decoder #(.XLEN(XLEN)) u_dec (
    .ir(ir), .ra(ra), .rb(rb), .rd(rd), .imm(imm), .alu_op(alu_op), .sel_imm_b(sel_imm_b),
    .branch(branch), .mem(mem), .mem_read(mem_read), .wb(wb), .comparison(comparison)
  );
  furv_alu #(.XLEN(XLEN)) u_alu (
    .op(alu_op), .a(branch ? pc : ra_v), .b(sel_imm_b ? imm : rb_v), .y(alu_y)
  );
  furv_regfile #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(ZERO_REG)) u_rf (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb), .rd(rd), .we(state == WB && wb),
    .wd((mem && mem_read) ? ld_q : d_q), .rda(ra_v), .rdb(rb_v)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= '0;
      d_q <= '0;
      wdata_q <= '0;
      ld_q <= '0;
      taken_q <= 1'b0;
      imem_req <= 1'b1;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      retire <= 1'b0;
    end else
      case (state)
        FETCH: if (imem_ack) begin
          ir <= imem_rdata;
          imem_req <= 1'b0;
          state <= EXEC;
        end
        EXEC: begin
          d_q <= alu_y;
          wdata_q <= rb_v;
          taken_q <= branch && cmp;
          dmem_req <= mem;
          dmem_we <= mem && !mem_read;
          retire <= !mem;
          state <= mem ? MEM : WB;
        end
        MEM: if (dmem_ack) begin
          ld_q <= dmem_rdata;
          dmem_req <= 1'b0;
          retire <= 1'b1;
          state <= WB;
        end
        default: begin
          pc <= taken_q ? d_q : pc + XLEN'(4);
          retire <= 1'b0;
          imem_req <= 1'b1;
          state <= FETCH;
        end
      endcase
endmodule

// File: tb/tb_furv_mc.sv
// tb_furv_mc: directed and random instructions against an instruction-level model of the core
module tb_furv_mc;
  localparam logic [31:0] RPC = 32'h100;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_req, imem_ack = 1'b0, dmem_req, dmem_we, dmem_ack = 1'b0, retire;
  logic [31:0] imem_addr, imem_rdata = '0, dmem_addr, dmem_wdata, dmem_rdata = '0, pc;
  int total = 0, bad = 0;
  logic [31:0] m_r [32];
  logic [31:0] m_pc;
  logic e_mem, e_st, e_wb;
  logic [4:0] e_rd;
  logic [31:0] e_addr, e_wdata, e_val, e_npc;
  always #5 clk = ~clk;
  furv_mc #(.XLEN(32), .NREGS(32), .RESET_PC(RPC), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .retire(retire), .pc(pc)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return sa < sb ? 32'd1 : 32'd0;
      3'd3: return a < b ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction
  task automatic model(input logic [31:0] insn, input logic [31:0] ld);
    logic [31:0] a, b, ii;
    logic [2:0] f3;
    int sa, sb;
    logic t;
    a = m_r[insn[19:15]];
    b = m_r[insn[24:20]];
    sa = a;
    sb = b;
    f3 = insn[14:12];
    ii = {{20{insn[31]}}, insn[31:20]};
    e_rd = insn[11:7];
    {e_mem, e_st, e_wb, e_addr, e_wdata, e_val} = '0;
    e_npc = m_pc + 32'd4;
    case (insn[6:0])
      7'h13: begin e_wb = 1'b1; e_val = ref_alu(f3, f3 == 3'd5 && insn[30], a, ii); end
      7'h33: begin e_wb = 1'b1; e_val = ref_alu(f3, insn[30], a, b); end
      7'h37: begin e_wb = 1'b1; e_val = {insn[31:12], 12'h0}; end
      7'h03: begin e_mem = 1'b1; e_wb = 1'b1; e_addr = a + ii; e_val = ld; end
      7'h23: begin e_mem = 1'b1; e_st = 1'b1; e_addr = a + {{20{insn[31]}}, insn[31:25], insn[11:7]}; e_wdata = b; end
      7'h63: begin
        t = f3[2:1] == 2'd0 ? a == b : f3[2:1] == 2'd2 ? sa < sb : a < b;
        if (t ^ f3[0]) e_npc = m_pc + {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      end
      default: ;
    endcase
  endtask
  // entered and left on a negedge with the core waiting in fetch
  task automatic exec(input logic [31:0] insn, input int fw, input int dw);
    logic [31:0] ld;
    ld = $urandom;
    model(insn, ld);
    chk("imem_req", imem_req, 1);
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("fetch_dmem_idle", dmem_req, 0);
    for (int i = 0; i < fw; i++) begin
      @(negedge clk);
      chk("imem_hold", {imem_req, imem_addr, retire}, {1'b1, m_pc, 1'b0});
    end
    imem_ack = 1'b1;
    imem_rdata = insn;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    chk("exec_idle", {imem_req, dmem_req, retire}, 0);
    if (e_mem) begin
      @(negedge clk);
      chk("dmem_req", {dmem_req, imem_req}, 2'b10);
      chk("dmem_we", dmem_we, e_st);
      chk("dmem_addr", dmem_addr, e_addr);
      if (e_st) chk("dmem_wdata", dmem_wdata, e_wdata);
      for (int i = 0; i < dw; i++) begin
        @(negedge clk);
        chk("dmem_hold", {dmem_req, dmem_we, dmem_addr, imem_req, retire}, {1'b1, e_st, e_addr, 2'b00});
      end
      dmem_ack = 1'b1;
      dmem_rdata = ld;
    end else begin
      dmem_ack = 1'($urandom_range(0, 1));
      imem_ack = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    imem_ack = 1'b0;
    dmem_rdata = $urandom;
    chk("retire", {retire, imem_req, dmem_req}, 3'b100);
    if (e_wb && e_rd != 5'd0) m_r[e_rd] = e_val;
    m_pc = e_npc;
    @(negedge clk);
    chk("retire_pulse", retire, 0);
  endtask
  task automatic goto(input logic [31:0] t);
    logic [31:0] d;
    d = t - m_pc;
    exec(enc_b(3'd0, 5'd0, 5'd0, d[12:0]), 0, 0);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) m_r[i] = '0;
    m_pc = RPC;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_imem_addr", imem_addr, RPC);
    chk("rst_imem_req", imem_req, 1);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_retire", retire, 0);
    exec(enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5), 0, 0);
    chk("addi_next_fetch", imem_addr, RPC + 32'd4);
    exec(enc_i(7'h03, 3'd2, 5'd2, 5'd0, 12'd0), 4, 3);
    exec(enc_s(5'd2, 5'd0, 12'd0), 0, 0);
    exec(enc_s(5'd1, 5'd0, 12'd8), 1, 1);
    chk("sw_x1", {dmem_addr, dmem_wdata}, {32'd8, 32'd5});
    exec(enc_i(7'h13, 3'd0, 5'd3, 5'd0, 12'hfff), 0, 0);
    exec(enc_i(7'h13, 3'd0, 5'd4, 5'd0, 12'd1), 0, 0);
    goto(32'h10);
    exec(enc_b(3'd0, 5'd0, 5'd0, 13'd8), 0, 0);
    chk("beq_equal", imem_addr, 32'h18);
    goto(32'h10);
    exec(enc_b(3'd0, 5'd1, 5'd0, 13'd8), 0, 0);
    chk("beq_unequal", imem_addr, 32'h14);
    goto(32'h10);
    exec(enc_b(3'd4, 5'd3, 5'd4, 13'd8), 0, 0);
    chk("blt_taken", imem_addr, 32'h18);
    goto(32'h10);
    exec(enc_b(3'd6, 5'd3, 5'd4, 13'd8), 0, 0);
    chk("bltu_not_taken", imem_addr, 32'h14);
    exec(enc_i(7'h13, 3'd0, 5'd0, 5'd0, 12'd7), 0, 0);
    exec(enc_s(5'd0, 5'd0, 12'd0), 0, 0);
    chk("x0_reads_zero", dmem_wdata, 0);
    for (int n = 0; n < 150; n++) begin
      logic [31:0] insn;
      logic [2:0] f3;
      logic [4:0] rd, r1, r2, sh;
      logic [11:0] im;
      logic alt;
      f3 = 3'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      r1 = 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      sh = 5'($urandom);
      im = 12'($urandom);
      alt = 1'($urandom);
      case ($urandom_range(0, 5))
        0: insn = enc_i(7'h13, f3, rd, r1, f3 == 3'd1 ? {7'b0, sh} : f3 == 3'd5 ? {1'b0, alt, 5'b0, sh} : im);
        1: insn = enc_r((f3 == 3'd0 || f3 == 3'd5) ? {1'b0, alt, 5'b0} : 7'b0, r2, r1, f3, rd);
        2: insn = {20'($urandom), rd, 7'h37};
        3: insn = enc_i(7'h03, 3'd2, rd, r1, im);
        4: insn = enc_s(r2, r1, im);
        default: insn = enc_b((f3 == 3'd2 || f3 == 3'd3) ? f3 + 3'd4 : f3, r1, r2, {{5{im[7]}}, im[7:1], 1'b0});
      endcase
      exec(insn, $urandom_range(0, 3), $urandom_range(0, 3));
      if (insn[6:0] inside {7'h13, 7'h33, 7'h37, 7'h03}) exec(enc_s(insn[11:7], 5'd0, 12'd0), 0, 0);
    end
    exec(enc_i(7'h13, 3'd0, 5'd5, 5'd0, 12'h055), 0, 0);
    chk("pre_rst_fetch", imem_req, 1);
    imem_ack = 1'b1;
    imem_rdata = enc_i(7'h03, 3'd2, 5'd5, 5'd0, 12'd4);
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    chk("mid_dmem_req", dmem_req, 1);
    #2 rst = 1'b1;
    #1 chk("rst_drops_dmem_req", {dmem_req, retire}, 2'b00);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hdead_beef;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) m_r[i] = '0;
    m_pc = RPC;
    chk("refetch", {imem_req, dmem_req, retire, imem_addr}, {3'b100, RPC});
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("late_ack_ignored", {imem_req, dmem_req, retire, imem_addr}, {3'b100, RPC});
    exec(enc_s(5'd5, 5'd0, 12'd0), 0, 0);
    chk("discarded_load", dmem_wdata, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
